remote_transmitter: RTL

- Transmit end of the serial remote-control link. Serialises one frame per request onto a single idle-high line that the remote-control receiver decodes.
- Frame, MSB first: lead 0, Custom[15:0], Key[7:0], ~Key[7:0], end 1. Total 34 bits.
- Used as the stimulus source for receiver system tests and as the transmit path in loopback designs.

---
 rtl/remote_transmitter_pkg.sv | 19 +
 rtl/remote_transmitter_if.sv | 22 ++
 rtl/remote_transmitter_bit_timer.sv | 29 ++
 rtl/remote_transmitter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/remote_transmitter_pkg.sv
// Shared definitions for the remote-control link (transmitter and receiver).
package remote_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        CUSTOM,
        KEY,
        INVKEY,
        END,
        GAP
    } tx_state_t;

    localparam int   CUSTOM_W   = 16;
    localparam int   KEY_W      = 8;
    localparam int   FRAME_BITS = 34;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/remote_transmitter_if.sv
// Request/line bundle between a frame source and the remote transmitter.
interface remote_tx_if;
    import remote_pkg::*;

    logic                start;
    logic [CUSTOM_W-1:0] custom;
    logic [KEY_W-1:0]    key;
    logic                serial;
    logic                busy;
    logic                done;

    modport master (
        output start, custom, key,
        input  serial, busy, done
    );

    modport slave (
        input  start, custom, key,
        output serial, busy, done
    );

endinterface

// File: rtl/remote_transmitter_bit_timer.sv
// Bit-period prescaler: bit_tick marks the last clock of each bit.
module remote_bit_timer #(
    parameter int BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic bit_tick
);

    localparam int            CW   = $clog2(BIT_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign bit_tick = enable && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= bit_tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/remote_transmitter.sv
// Remote-control frame serialiser: 0, custom, key, ~key, 1 (MSB first).
// Define REMOTE_TX_GAP_EN to enforce GAP_CYCLES idle-high cycles after each frame.
module remote_transmitter
    import remote_pkg::*;
#(
    parameter int BIT_CYCLES = 1,
    parameter int GAP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    remote_tx_if.slave  tx
);

    tx_state_t           state, state_n;
    logic [3:0]          bit_cnt, bit_n;
    logic                serial_q, serial_n;
    logic                busy_q, busy_n;
    logic                done_q, done_n;
    logic [CUSTOM_W-1:0] custom_q;
    logic [KEY_W-1:0]    key_q;
    logic                latch;
    logic                tick;
    logic                run;
    logic [3:0]          c_idx;
    logic [2:0]          k_idx;

`ifdef REMOTE_TX_GAP_EN
    localparam int GW = $clog2(GAP_CYCLES + 1) + 1;
    logic [GW-1:0] gap_cnt, gap_n;
`endif

    assign run   = (state != IDLE) && (state != GAP);
    assign c_idx = 4'd14 - bit_cnt;
    assign k_idx = 3'd6 - bit_cnt[2:0];

    remote_bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state == IDLE),
        .enable   (run),
        .bit_tick (tick)
    );

    always_comb begin
        state_n  = state;
        bit_n    = bit_cnt;
        serial_n = serial_q;
        busy_n   = busy_q;
        done_n   = 1'b0;
        latch    = 1'b0;
`ifdef REMOTE_TX_GAP_EN
        gap_n    = gap_cnt;
`endif
        case (state)
            IDLE: begin
                serial_n = IDLE_LEVEL;
                busy_n   = 1'b0;
                if (tx.start) begin
                    latch    = 1'b1;
                    state_n  = LEAD;
                    bit_n    = '0;
                    serial_n = 1'b0;
                    busy_n   = 1'b1;
                end
            end
            LEAD: if (tick) begin
                state_n  = CUSTOM;
                bit_n    = '0;
                serial_n = custom_q[CUSTOM_W-1];
            end
            CUSTOM: if (tick) begin
                if (bit_cnt == 4'd15) begin
                    state_n  = KEY;
                    bit_n    = '0;
                    serial_n = key_q[KEY_W-1];
                end else begin
                    bit_n    = bit_cnt + 4'd1;
                    serial_n = custom_q[c_idx];
                end
            end
            KEY: if (tick) begin
                if (bit_cnt == 4'd7) begin
                    state_n  = INVKEY;
                    bit_n    = '0;
                    serial_n = ~key_q[KEY_W-1];
                end else begin
                    bit_n    = bit_cnt + 4'd1;
                    serial_n = key_q[k_idx];
                end
            end
            INVKEY: if (tick) begin
                if (bit_cnt == 4'd7) begin
                    state_n  = END;
                    bit_n    = '0;
                    serial_n = IDLE_LEVEL;
                end else begin
                    bit_n    = bit_cnt + 4'd1;
                    serial_n = ~key_q[k_idx];
                end
            end
            END: if (tick) begin
                done_n   = 1'b1;
                serial_n = IDLE_LEVEL;
`ifdef REMOTE_TX_GAP_EN
                state_n  = GAP;
                gap_n    = '0;
`else
                state_n  = IDLE;
                busy_n   = 1'b0;
`endif
            end
`ifdef REMOTE_TX_GAP_EN
            GAP: begin
                serial_n = IDLE_LEVEL;
                if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else begin
                    gap_n = gap_cnt + GW'(1);
                end
            end
`endif
            default: begin
                state_n  = IDLE;
                serial_n = IDLE_LEVEL;
                busy_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            serial_q <= IDLE_LEVEL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            custom_q <= '0;
            key_q    <= '0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_n;
            serial_q <= serial_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
            if (latch) begin
                custom_q <= tx.custom;
                key_q    <= tx.key;
            end
        end
    end

`ifdef REMOTE_TX_GAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= gap_n;
        end
    end
`endif

    assign tx.serial = serial_q;
    assign tx.busy   = busy_q;
    assign tx.done   = done_q;

endmodule
